// File: rtl/counter_bg_param.sv
// Purpose : WIDTH-bit up/down counter, binary or Gray output, parallel load, wrap pulse.
// Latency : 1 cycle from inputs to count/index/tc (all outputs registered).
// Backpr. : none; en acts as a hold, load overrides en every cycle.
//
// Build option: define BG_COUNTER_SAT_EN to saturate at the ends instead of wrapping.
// In that mode tc flags every enabled edge that is blocked at an end.
// The tc flag stays high for as long as the blocked condition persists.
module counter_bg_param #(
  parameter int WIDTH     = 3,
  parameter int RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             mode,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] index,
  output logic             tc
);

  localparam logic [WIDTH-1:0] RST_IDX = WIDTH'(RESET_VAL);
  localparam logic [WIDTH-1:0] IDX_MAX = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] IDX_MIN = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] IDX_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] index_q, index_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;

  logic             at_max;
  logic             at_min;
  logic [WIDTH-1:0] index_inc;
  logic [WIDTH-1:0] index_dec;

  assign at_max    = (index_q == IDX_MAX);
  assign at_min    = (index_q == IDX_MIN);
  assign index_inc = index_q + IDX_ONE;
  assign index_dec = index_q - IDX_ONE;

  // Next index and wrap flag: load beats count, count beats hold.
  always_comb begin
    index_d = index_q;
    tc_d    = 1'b0;
    if (load) begin
      index_d = load_val;
      tc_d    = 1'b0;
    end else if (en && !dir) begin
`ifdef BG_COUNTER_SAT_EN
      if (at_max) begin
        index_d = index_q;
        tc_d    = 1'b1;
      end else begin
        index_d = index_inc;
        tc_d    = 1'b0;
      end
`else
      index_d = index_inc;
      tc_d    = at_max;
`endif
    end else if (en && dir) begin
`ifdef BG_COUNTER_SAT_EN
      if (at_min) begin
        index_d = index_q;
        tc_d    = 1'b1;
      end else begin
        index_d = index_dec;
        tc_d    = 1'b0;
      end
`else
      index_d = index_dec;
      tc_d    = at_min;
`endif
    end
  end

  // Output encoding follows the next index, so a mode change alone re-encodes in place.
  always_comb begin
    count_d = index_d;
    if (mode) begin
      count_d = index_d ^ (index_d >> 1);
    end
  end

  // State registers; reset clears immediately and count comes back as binary RESET_VAL.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      index_q <= RST_IDX;
      count_q <= RST_IDX;
      tc_q    <= 1'b0;
    end else begin
      index_q <= index_d;
      count_q <= count_d;
      tc_q    <= tc_d;
    end
  end

  assign index = index_q;
  assign count = count_q;
  assign tc    = tc_q;

endmodule

// File: tb/tb_counter_bg_param.sv
// Directed bench for counter_bg_param at WIDTH=3, RESET_VAL=0.
// Inputs change 1 time unit after a rising edge; outputs are checked at that same point.
// Define BG_COUNTER_SAT_EN for both files to exercise the saturating build.
module tb_counter_bg_param;

  localparam int W = 3;

  logic         clk;
  logic         reset;
  logic         en;
  logic         mode;
  logic         dir;
  logic         load;
  logic [W-1:0] load_val;
  logic [W-1:0] count;
  logic [W-1:0] index;
  logic         tc;

  int total;
  int bad;

  counter_bg_param #(.WIDTH(W), .RESET_VAL(0)) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .mode     (mode),
    .dir      (dir),
    .load     (load),
    .load_val (load_val),
    .count    (count),
    .index    (index),
    .tc       (tc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point for the whole bench.
  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Check all three outputs at once.
  task automatic chk3(input string tag, input int e_idx, input int e_cnt, input int e_tc);
    chk({tag, ".index"}, int'(index), e_idx);
    chk({tag, ".count"}, int'(count), e_cnt);
    chk({tag, ".tc"},    int'(tc),    e_tc);
  endtask

  int gray_seq [8] = '{1, 3, 2, 6, 7, 5, 4, 0};
  logic [W-1:0] prev_cnt;

  initial begin
    total    = 0;
    bad      = 0;
    reset    = 1'b0;
    en       = 1'b0;
    mode     = 1'b0;
    dir      = 1'b0;
    load     = 1'b0;
    load_val = '0;

    // Reset held for two edges.
    step();
    step();
    chk3("reset", 0, 0, 0);
    reset = 1'b1;

    // Binary up count through a full wrap.
    en = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step();
      chk3($sformatf("bin_up%0d", k), k % 8, k % 8, (k == 8) ? 1 : 0);
    end

    // Gray up count, one bit change per step, wrap pulse after 100->000.
    mode = 1'b1;
    prev_cnt = count;
    for (int k = 0; k < 8; k++) begin
      step();
      chk3($sformatf("gray_up%0d", k), (k + 1) % 8, gray_seq[k], (k == 7) ? 1 : 0);
      chk($sformatf("gray_hd%0d", k), $countones(count ^ prev_cnt), 1);
      prev_cnt = count;
    end

    // Binary to index 5, then idle mode switch re-encodes in place.
    mode = 1'b0;
    for (int k = 1; k <= 5; k++) step();
    chk3("bin_to5", 5, 5, 0);
    en   = 1'b0;
    mode = 1'b1;
    step();
    chk3("idle_mode_sw", 5, 7, 0);
    en  = 1'b1;
    dir = 1'b1;
    step();
    chk3("gray_down4", 4, 6, 0);
    dir = 1'b0;
    step();
    chk3("dir_flip_up5", 5, 7, 0);

    // Load overrides en; then count up to the top.
    mode     = 1'b0;
    load     = 1'b1;
    load_val = 3'd6;
    step();
    chk3("load6", 6, 6, 0);
    load = 1'b0;
    step();
    chk3("after_load7", 7, 7, 0);

`ifdef BG_COUNTER_SAT_EN
    for (int k = 0; k < 3; k++) begin
      step();
      chk3($sformatf("sat_top%0d", k), 7, 7, 1);
    end
    dir = 1'b1;
    step();
    chk3("sat_leave_top", 6, 6, 0);
    load     = 1'b1;
    load_val = 3'd0;
    step();
    chk3("sat_load0", 0, 0, 0);
    load = 1'b0;
    step();
    chk3("sat_bottom", 0, 0, 1);
`else
    step();
    chk3("wrap_up0", 0, 0, 1);
    en = 1'b0;
    step();
    chk3("idle_no_tc", 0, 0, 0);
    en  = 1'b1;
    dir = 1'b1;
    step();
    chk3("wrap_down7", 7, 7, 1);
    step();
    chk3("down6", 6, 6, 0);
`endif

    // Asynchronous reset mid-count at index 3, no clock edge in between.
    en       = 1'b0;
    dir      = 1'b0;
    mode     = 1'b0;
    load     = 1'b1;
    load_val = 3'd3;
    step();
    chk3("load3", 3, 3, 0);
    load = 1'b0;
    en   = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    chk3("async_rst", 0, 0, 0);
    #2;
    reset = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      step();
      chk3($sformatf("resume%0d", k), k, k, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Guard against a stalled run.
  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
